sprite_engine: RTL and testbench

SPRITE_ENGINE -- requirements
Module: sprite_engine

---
 rtl/sprite_engine.sv | 155 +++++++++++++++
 tb/tb_sprite_engine.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_engine.sv
// Sprite engine: moves a WIDTH x HEIGHT sprite, then draws or erases it one pixel per clock.
// Optional macro SPRITE_BITMAP_EN adds a BITMAP parameter that makes selected pixels transparent.
module sprite_engine #(
  parameter int         WIDTH  = 16,
  parameter int         HEIGHT = 16,
  parameter logic [2:0] COLOUR = 3'b111
`ifdef SPRITE_BITMAP_EN
  , parameter logic [WIDTH*HEIGHT-1:0] BITMAP = '1
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       select,
  input  logic       load,
  input  logic [7:0] load_x,
  input  logic [6:0] load_y,
  input  logic       writeEn,
  input  logic       clear,
  input  logic       shift_h,
  input  logic       shift_v,
  input  logic [6:0] shift_amount,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       complete,
  output logic [7:0] pos_x,
  output logic [6:0] pos_y
);

  typedef enum logic [1:0] {IDLE, MOVE, DRAW, DONE} state_t;

  localparam logic [6:0] Y_MAX = 7'(120 - HEIGHT);

  state_t     state, state_next;
  logic [7:0] pos_x_next;
  logic [6:0] pos_y_next;
  logic [3:0] cx, cx_next, cy, cy_next;
  logic       clear_reg, clear_next;
  logic       shift_h_reg, shift_h_next;
  logic       shift_v_reg, shift_v_next;
  logic [6:0] amount_reg, amount_next;
  logic [8:0] y_sum;
  logic [7:0] x_pix;
  logic [6:0] y_pix;
  logic       pixel_on;
  logic       load_cmd;

  assign load_cmd = select && load;
  // 9-bit two's-complement sum so both underflow and overflow are visible for saturation
  assign y_sum    = {2'b00, pos_y} + {{2{amount_reg[6]}}, amount_reg};
  assign x_pix    = pos_x + {4'b0000, cx};
  assign y_pix    = pos_y + {3'b000, cy};

`ifdef SPRITE_BITMAP_EN
  logic [7:0] pix_idx;
  assign pix_idx  = 8'(cy * WIDTH) + {4'b0000, cx};
  assign pixel_on = BITMAP[pix_idx];
`else
  assign pixel_on = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pos_x       <= '0;
      pos_y       <= '0;
      cx          <= '0;
      cy          <= '0;
      clear_reg   <= 1'b0;
      shift_h_reg <= 1'b0;
      shift_v_reg <= 1'b0;
      amount_reg  <= '0;
    end else begin
      state       <= state_next;
      pos_x       <= pos_x_next;
      pos_y       <= pos_y_next;
      cx          <= cx_next;
      cy          <= cy_next;
      clear_reg   <= clear_next;
      shift_h_reg <= shift_h_next;
      shift_v_reg <= shift_v_next;
      amount_reg  <= amount_next;
    end
  end

  always_comb begin
    state_next   = state;
    pos_x_next   = pos_x;
    pos_y_next   = pos_y;
    cx_next      = cx;
    cy_next      = cy;
    clear_next   = clear_reg;
    shift_h_next = shift_h_reg;
    shift_v_next = shift_v_reg;
    amount_next  = amount_reg;
    // A load from the controller wins in every state and abandons any operation in flight
    if (load_cmd) begin
      pos_x_next = load_x;
      pos_y_next = load_y;
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (select && writeEn) begin
            clear_next   = clear;
            shift_h_next = shift_h;
            shift_v_next = shift_v;
            amount_next  = shift_amount;
            state_next   = MOVE;
          end
        end
        MOVE: begin
          if (!clear_reg) begin
            if (shift_h_reg) pos_x_next = pos_x + {amount_reg[6], amount_reg};
            if (shift_v_reg) begin
              if (y_sum[8])                   pos_y_next = '0;
              else if (y_sum > {2'b00, Y_MAX}) pos_y_next = Y_MAX;
              else                            pos_y_next = y_sum[6:0];
            end
          end
          cx_next    = '0;
          cy_next    = '0;
          state_next = DRAW;
        end
        DRAW: begin
          if (cx == 4'(WIDTH - 1)) begin
            cx_next = '0;
            if (cy == 4'(HEIGHT - 1)) state_next = DONE;
            else                      cy_next    = cy + 4'd1;
          end else begin
            cx_next = cx + 4'd1;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    x        = '0;
    y        = '0;
    colour   = '0;
    plot     = 1'b0;
    complete = (state == DONE) && !load_cmd;
    if (state == DRAW) begin
      x      = x_pix;
      y      = y_pix;
      colour = clear_reg ? 3'b000 : COLOUR;
      plot   = (x_pix < 8'd160) && (y_pix < 7'd120) && pixel_on;
    end
  end

endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine: expected pixels are queued per command and
// popped as the DUT plots them; timing, positions, abort and reset are checked inline.
module tb_sprite_engine;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       select = 1'b0, load = 1'b0, writeEn = 1'b0;
  logic       clear = 1'b0, shift_h = 1'b0, shift_v = 1'b0;
  logic [7:0] load_x = '0;
  logic [6:0] load_y = '0;
  logic [6:0] shift_amount = '0;
  logic [7:0] x, pos_x;
  logic [6:0] y, pos_y;
  logic [2:0] colour;
  logic       plot, complete;

  int tests = 0;
  int fails = 0;
  logic [17:0] exp_q[$];

  typedef struct packed {
    logic [7:0] lx;
    logic [6:0] ly;
    logic       clr;
    logic       sh;
    logic       sv;
    logic [6:0] amt;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [8:0] cnt;
  } op_t;

  always #5 clock = ~clock;

  sprite_engine dut (
    .clock(clock), .reset(reset), .select(select), .load(load),
    .load_x(load_x), .load_y(load_y), .writeEn(writeEn), .clear(clear),
    .shift_h(shift_h), .shift_v(shift_v), .shift_amount(shift_amount),
    .x(x), .y(y), .colour(colour), .plot(plot), .complete(complete),
    .pos_x(pos_x), .pos_y(pos_y)
  );

  function automatic void push_sprite(input logic [7:0] px, input logic [6:0] py, input logic [2:0] col);
    logic [7:0] xx;
    logic [6:0] yy;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        xx = px + 8'(c);
        yy = py + 7'(r);
        if (xx < 8'd160 && yy < 7'd120) exp_q.push_back({xx, yy, col});
      end
  endfunction

  task automatic do_load(input logic [7:0] lx, input logic [6:0] ly);
    @(negedge clock);
    select = 1'b1; load = 1'b1; load_x = lx; load_y = ly;
    @(negedge clock);
    select = 1'b0; load = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({x, y, colour, plot, complete, pos_x, pos_y} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got x=%0d y=%0d col=%0d plot=%b cmp=%b pos=(%0d,%0d), want all 0",
               x, y, colour, plot, complete, pos_x, pos_y);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if ({plot, complete, pos_x, pos_y} !== '0) begin
      fails++;
      $display("FAIL reset_idle: got plot=%b cmp=%b pos=(%0d,%0d), want 0", plot, complete, pos_x, pos_y);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_draw_table();
    op_t ops[7];
    ops[0] = '{8'd72,  7'd52,  1'b0, 1'b0, 1'b0, 7'd0,   8'd72,  7'd52,  9'd256};
    ops[1] = '{8'd250, 7'd10,  1'b0, 1'b1, 1'b0, 7'd10,  8'd4,   7'd10,  9'd256};
    ops[2] = '{8'd0,   7'd100, 1'b0, 1'b0, 1'b1, 7'h7F,  8'd0,   7'd99,  9'd256};
    ops[3] = '{8'd0,   7'd104, 1'b0, 1'b0, 1'b1, 7'd5,   8'd0,   7'd104, 9'd256};
    ops[4] = '{8'd150, 7'd30,  1'b1, 1'b1, 1'b0, 7'd5,   8'd150, 7'd30,  9'd160};
    ops[5] = '{8'd20,  7'd3,   1'b0, 1'b1, 1'b1, 7'h76,  8'd10,  7'd0,   9'd256};
    ops[6] = '{8'd10,  7'd110, 1'b0, 1'b0, 1'b0, 7'd0,   8'd10,  7'd110, 9'd160};
    for (int i = 0; i < 7; i++) begin
      int cyc, done_cyc, n_plot;
      logic [17:0] e;
      do_load(ops[i].lx, ops[i].ly);
      tests++;
      if (pos_x !== ops[i].lx || pos_y !== ops[i].ly) begin
        fails++;
        $display("FAIL load_pos op%0d: got (%0d,%0d), want (%0d,%0d)", i, pos_x, pos_y, ops[i].lx, ops[i].ly);
      end
      exp_q.delete();
      push_sprite(ops[i].ex, ops[i].ey, ops[i].clr ? 3'b000 : 3'b111);
      select = 1'b1; writeEn = 1'b1; clear = ops[i].clr;
      shift_h = ops[i].sh; shift_v = ops[i].sv; shift_amount = ops[i].amt;
      cyc = 0; done_cyc = -1; n_plot = 0;
      while (cyc < 300 && done_cyc < 0) begin
        @(negedge clock);
        cyc++;
        if (cyc == 1) begin
          select = 1'b0; writeEn = 1'b0; clear = ~clear; shift_h = ~shift_h;
          shift_v = ~shift_v; shift_amount = 7'h2A;
        end
        if (cyc == 2) begin
          tests++;
          if (pos_x !== ops[i].ex || pos_y !== ops[i].ey) begin
            fails++;
            $display("FAIL moved_pos op%0d: got (%0d,%0d), want (%0d,%0d)", i, pos_x, pos_y, ops[i].ex, ops[i].ey);
          end
        end
        if (plot) begin
          n_plot++;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL extra_pixel op%0d: got (%0d,%0d), want no plot", i, x, y);
          end else begin
            e = exp_q.pop_front();
            if ({x, y, colour} !== e) begin
              fails++;
              $display("FAIL pixel op%0d: got (%0d,%0d,c%0d), want (%0d,%0d,c%0d)",
                       i, x, y, colour, e[17:10], e[9:3], e[2:0]);
            end
          end
        end
        if (complete) done_cyc = cyc;
      end
      tests++;
      if (done_cyc != 258) begin
        fails++;
        $display("FAIL complete_cycle op%0d: got %0d, want 258", i, done_cyc);
      end
      tests++;
      if (n_plot != int'(ops[i].cnt) || exp_q.size() != 0) begin
        fails++;
        $display("FAIL plot_count op%0d: got %0d, want %0d", i, n_plot, ops[i].cnt);
      end
      clear = 1'b0; shift_h = 1'b0; shift_v = 1'b0; shift_amount = '0;
      @(negedge clock);
      tests++;
      if (complete !== 1'b0 || plot !== 1'b0) begin
        fails++;
        $display("FAIL complete_width op%0d: got complete=%b plot=%b, want 0", i, complete, plot);
      end
      $display("[TB] op%0d pos=(%0d,%0d) plots=%0d done@%0d", i, pos_x, pos_y, n_plot, done_cyc);
    end
  endtask

  task automatic test_abort();
    int n_done;
    do_load(8'd72, 7'd52);
    select = 1'b1; writeEn = 1'b1;
    n_done = 0;
    for (int cyc = 1; cyc < 300; cyc++) begin
      @(negedge clock);
      if (complete) n_done++;
      if (cyc == 1) begin select = 1'b0; writeEn = 1'b0; end
      if (cyc == 42) begin
        tests++;
        if (plot !== 1'b1 || x !== 8'd80 || y !== 7'd54) begin
          fails++;
          $display("FAIL abort_pixel40: got plot=%b (%0d,%0d), want plot=1 (80,54)", plot, x, y);
        end
        select = 1'b1; load = 1'b1; load_x = 8'd0; load_y = 7'd20;
      end
      if (cyc == 43) begin
        select = 1'b0; load = 1'b0;
        tests++;
        if (plot !== 1'b0 || pos_x !== 8'd0 || pos_y !== 7'd20) begin
          fails++;
          $display("FAIL abort_stop: got plot=%b pos=(%0d,%0d), want plot=0 pos=(0,20)", plot, pos_x, pos_y);
        end
      end
    end
    tests++;
    if (n_done != 0) begin
      fails++;
      $display("FAIL abort_complete: got %0d complete pulses, want 0", n_done);
    end
    $display("[TB] abort pos=(%0d,%0d) completes=%0d", pos_x, pos_y, n_done);
  endtask

  task automatic test_back_to_back();
    int cyc, n_done;
    int done_at[2];
    logic [17:0] e;
    do_load(8'd40, 7'd40);
    exp_q.delete();
    push_sprite(8'd40, 7'd40, 3'b000);
    push_sprite(8'd41, 7'd40, 3'b111);
    select = 1'b1; writeEn = 1'b1; clear = 1'b1; shift_h = 1'b1; shift_amount = 7'd1;
    cyc = 0; n_done = 0; done_at[0] = -1; done_at[1] = -1;
    while (cyc < 600 && n_done < 2) begin
      @(negedge clock);
      cyc++;
      if (cyc == 3) clear = 1'b0;
      if (cyc == 260) begin select = 1'b0; writeEn = 1'b0; shift_h = 1'b0; end
      if (plot) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL b2b_extra_pixel: got (%0d,%0d), want no plot", x, y);
        end else begin
          e = exp_q.pop_front();
          if ({x, y, colour} !== e) begin
            fails++;
            $display("FAIL b2b_pixel: got (%0d,%0d,c%0d), want (%0d,%0d,c%0d)",
                     x, y, colour, e[17:10], e[9:3], e[2:0]);
          end
        end
      end
      if (complete) begin done_at[n_done] = cyc; n_done++; end
    end
    select = 1'b0; writeEn = 1'b0; shift_h = 1'b0;
    tests++;
    if (done_at[0] != 258 || done_at[1] != 517) begin
      fails++;
      $display("FAIL b2b_complete: got %0d,%0d, want 258,517", done_at[0], done_at[1]);
    end
    tests++;
    if (exp_q.size() != 0 || pos_x !== 8'd41 || pos_y !== 7'd40) begin
      fails++;
      $display("FAIL b2b_end: got left=%0d pos=(%0d,%0d), want left=0 pos=(41,40)", exp_q.size(), pos_x, pos_y);
    end
    $display("[TB] back_to_back done@%0d,%0d pos=(%0d,%0d)", done_at[0], done_at[1], pos_x, pos_y);
  endtask

  task automatic test_async_reset();
    int n_done;
    do_load(8'd72, 7'd52);
    select = 1'b1; writeEn = 1'b1;
    for (int cyc = 1; cyc <= 102; cyc++) begin
      @(negedge clock);
      if (cyc == 1) begin select = 1'b0; writeEn = 1'b0; end
    end
    tests++;
    if (plot !== 1'b1 || x !== 8'd76 || y !== 7'd58) begin
      fails++;
      $display("FAIL pre_reset_pixel100: got plot=%b (%0d,%0d), want plot=1 (76,58)", plot, x, y);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({x, y, colour, plot, complete, pos_x, pos_y} !== '0) begin
      fails++;
      $display("FAIL async_reset: got x=%0d y=%0d col=%0d plot=%b cmp=%b pos=(%0d,%0d), want all 0",
               x, y, colour, plot, complete, pos_x, pos_y);
    end
    @(negedge clock);
    reset = 1'b1;
    n_done = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clock);
      if (complete || plot) n_done++;
    end
    tests++;
    if (n_done != 0) begin
      fails++;
      $display("FAIL reset_discard: got %0d plot/complete cycles, want 0", n_done);
    end
    $display("[TB] async reset mid-draw, activity after=%0d", n_done);
  endtask

  initial begin
    test_reset();
    test_draw_table();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
